// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised register file with NUM_RD combinational read
// ports, rising-edge write with same-cycle write-to-read bypass, and a
// per-register busy scoreboard with a registered busy count.
// Optional build macro RF_DEBUG_PORT_EN adds a read-only dbg_addr/dbg_data tap.
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     flush,
`ifdef RF_DEBUG_PORT_EN
   input  logic [ADDR_W-1:0]        dbg_addr,
   output logic [DATA_W-1:0]        dbg_data,
`endif
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int Depth  = 2**ADDR_W;
   localparam int CntW   = ADDR_W + 1;
   localparam bit ZeroOn = (ZERO_REG != 0);

   generate
      if (NUM_RD < 1 || NUM_RD > 4) begin : gBadNumRd
         $error("regfile_mp_sb: NUM_RD must be in 1..4");
      end
   endgenerate

   logic [DATA_W-1:0] regs [Depth];
   logic [Depth-1:0]  busy;
   logic [Depth-1:0]  busyNext;
   logic [CntW-1:0]   busyCnt;
   logic [CntW-1:0]   cntNext;
   logic              wrAccept;
   logic              issAccept;
   logic              setNew;
   logic              clrOld;

   // Register 0 swallows writes and issues when it is hard-wired to zero.
   assign wrAccept  = wr_en  && !(ZeroOn && wr_addr  == '0);
   assign issAccept = iss_en && !(ZeroOn && iss_addr == '0);

   // Next busy vector: flush clears everything, issue overrides a same-index writeback.
   always_comb begin
      busyNext = busy;
      if (flush) begin
         busyNext = '0;
      end else begin
         if (wr_en)     busyNext[wr_addr]  = 1'b0;
         if (issAccept) busyNext[iss_addr] = 1'b1;
      end
   end

   // Count delta derived from the bits that actually change, so the count tracks the popcount.
   always_comb begin
      setNew  = issAccept && !busy[iss_addr];
      clrOld  = wr_en && busy[wr_addr] && !(issAccept && iss_addr == wr_addr);
      cntNext = busyCnt;
      if (flush)
         cntNext = '0;
      else if (setNew && !clrOld)
         cntNext = busyCnt + CntW'(1);
      else if (clrOld && !setNew)
         cntNext = busyCnt - CntW'(1);
   end

   // Data array: cleared by reset, written on the rising edge (flush does not block writes).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < Depth; r++) regs[r] <= '0;
      end else if (wrAccept) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Scoreboard state and its population count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= '0;
         busyCnt <= '0;
      end else begin
         busy    <= busyNext;
         busyCnt <= cntNext;
      end
   end

   assign busy_cnt = busyCnt;

   for (genvar i = 0; i < NUM_RD; i++) begin : gRead
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              bsy;

      assign addr = rd_addr[i*ADDR_W +: ADDR_W];

      // Read mux: zero register first, then writeback bypass, then array and scoreboard.
      always_comb begin
         data = regs[addr];
         bsy  = busy[addr];
         if (ZeroOn && addr == '0) begin
            data = '0;
            bsy  = 1'b0;
         end else if (wr_en && !rst && wr_addr == addr) begin
            data = wr_data;
            bsy  = 1'b0;
         end
      end

      assign rd_data[i*DATA_W +: DATA_W] = data;
      assign rd_busy[i]                  = bsy;
   end

`ifdef RF_DEBUG_PORT_EN
   // Board-display tap: array contents only, no bypass, no scoreboard interaction.
   always_comb begin
      dbg_data = regs[dbg_addr];
      if (ZeroOn && dbg_addr == '0) dbg_data = '0;
   end
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Testbench for regfile_mp_sb: directed scenarios plus randomized traffic
// against an array-based reference model; a second 4-port 64-bit instance
// covers wide multi-port reads.
module tb_regfile_mp_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  rdAddr = '0;
   logic [63:0] rdData;
   logic [1:0]  rdBusy;
   logic        wrEn = 1'b0;
   logic [4:0]  wrAddr = '0;
   logic [31:0] wrData = '0;
   logic        issEn = 1'b0;
   logic [4:0]  issAddr = '0;
   logic        flush = 1'b0;
   logic [5:0]  busyCnt;
`ifdef RF_DEBUG_PORT_EN
   logic [4:0]  dbgAddr = '0;
   logic [31:0] dbgData;
   logic [3:0]  wDbgAddr = '0;
   logic [63:0] wDbgData;
`endif

   logic [15:0]  wRdAddr = '0;
   logic [255:0] wRdData;
   logic [3:0]   wRdBusy;
   logic         wWrEn = 1'b0;
   logic [3:0]   wWrAddr = '0;
   logic [63:0]  wWrData = '0;
   logic         wIssEn = 1'b0;
   logic [3:0]   wIssAddr = '0;
   logic         wFlush = 1'b0;
   logic [4:0]   wBusyCnt;

   int passCount = 0;
   int checkCount = 0;

   logic [31:0] mReg [32];
   bit          mBusy [32];
   logic [63:0] wVal [4];

   always #5 clk = ~clk;

   regfile_mp_sb dut (
      .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .iss_en(issEn), .iss_addr(issAddr), .flush(flush),
`ifdef RF_DEBUG_PORT_EN
      .dbg_addr(dbgAddr), .dbg_data(dbgData),
`endif
      .busy_cnt(busyCnt)
   );

   regfile_mp_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dutWide (
      .clk(clk), .rst(rst), .rd_addr(wRdAddr), .rd_data(wRdData), .rd_busy(wRdBusy),
      .wr_en(wWrEn), .wr_addr(wWrAddr), .wr_data(wWrData),
      .iss_en(wIssEn), .iss_addr(wIssAddr), .flush(wFlush),
`ifdef RF_DEBUG_PORT_EN
      .dbg_addr(wDbgAddr), .dbg_data(wDbgData),
`endif
      .busy_cnt(wBusyCnt)
   );

   // ---------------- reference model ----------------
   function automatic void modelReset();
      for (int r = 0; r < 32; r++) begin
         mReg[r]  = '0;
         mBusy[r] = 1'b0;
      end
   endfunction

   // Apply one rising edge using the rules: write data, then per-register busy update.
   function automatic void modelEdge();
      if (wrEn && wrAddr != 5'd0) mReg[wrAddr] = wrData;
      for (int r = 1; r < 32; r++) begin
         if (flush)                             mBusy[r] = 1'b0;
         else if (issEn && int'(issAddr) == r)  mBusy[r] = 1'b1;
         else if (wrEn && int'(wrAddr) == r)    mBusy[r] = 1'b0;
      end
   endfunction

   function automatic int modelCount();
      int n = 0;
      for (int r = 0; r < 32; r++) n += int'(mBusy[r]);
      return n;
   endfunction

   // Expected combinational read for the current (pre-edge) inputs.
   function automatic logic [32:0] modelRead(input logic [4:0] a);
      if (a == 5'd0)              return 33'd0;
      if (wrEn && wrAddr == a)    return {1'b0, wrData};
      return {mBusy[a], mReg[a]};
   endfunction

   task automatic tick();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   task automatic clearStrobes();
      wrEn = 1'b0; issEn = 1'b0; flush = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rdAddr = {5'd31, 5'd5};
      #2 rst = 1'b1;
      #1;
      if (rdData !== 64'd0) begin
         $display("FAIL reset_rd_data got %h exp %h", rdData, 64'd0);
      end else passCount++;
      checkCount++;
      if (rdBusy !== 2'b00) begin
         $display("FAIL reset_rd_busy got %b exp %b", rdBusy, 2'b00);
      end else passCount++;
      checkCount++;
      if (busyCnt !== 6'd0) begin
         $display("FAIL reset_busy_cnt got %0d exp 0", busyCnt);
      end else passCount++;
      checkCount++;
      #1 rst = 1'b0;
      modelReset();
      @(negedge clk);
   endtask

   task automatic test_write_bypass();
      wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hDEADBEEF;
      rdAddr = {5'd0, 5'd7};
      #1;
      if (rdData[31:0] !== 32'hDEADBEEF || rdBusy[0] !== 1'b0) begin
         $display("FAIL bypass_same_cycle got %h/%b exp deadbeef/0", rdData[31:0], rdBusy[0]);
      end else passCount++;
      checkCount++;
      tick();
      clearStrobes();
      #1;
      if (rdData[31:0] !== 32'hDEADBEEF) begin
         $display("FAIL write_next_cycle got %h exp deadbeef", rdData[31:0]);
      end else passCount++;
      checkCount++;
   endtask

   task automatic test_zero_reg();
      int cntBefore;
      cntBefore = modelCount();
      wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'h12345678;
      issEn = 1'b1; issAddr = 5'd0;
      rdAddr = {5'd0, 5'd0};
      #1;
      if (rdData !== 64'd0 || rdBusy !== 2'b00) begin
         $display("FAIL zero_same_cycle got %h/%b exp 0/00", rdData, rdBusy);
      end else passCount++;
      checkCount++;
      tick();
      clearStrobes();
      #1;
      if (rdData[31:0] !== 32'd0 || rdBusy[0] !== 1'b0) begin
         $display("FAIL zero_after got %h/%b exp 0/0", rdData[31:0], rdBusy[0]);
      end else passCount++;
      checkCount++;
      if (int'(busyCnt) !== cntBefore) begin
         $display("FAIL zero_busy_cnt got %0d exp %0d", busyCnt, cntBefore);
      end else passCount++;
      checkCount++;
   endtask

   task automatic test_scoreboard();
      issEn = 1'b1; issAddr = 5'd3;
      tick();
      if (busyCnt !== 6'd1) begin
         $display("FAIL sb_cnt_one got %0d exp 1", busyCnt);
      end else passCount++;
      checkCount++;
      issAddr = 5'd4;
      rdAddr = {5'd4, 5'd3};
      #1;
      if (rdBusy !== 2'b01) begin
         $display("FAIL sb_busy_x3 got %b exp 01", rdBusy);
      end else passCount++;
      checkCount++;
      tick();
      if (busyCnt !== 6'd2 || rdBusy !== 2'b11) begin
         $display("FAIL sb_cnt_two got %0d/%b exp 2/11", busyCnt, rdBusy);
      end else passCount++;
      checkCount++;
      issEn = 1'b0;
      wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'h55;
      #1;
      if (rdData[31:0] !== 32'h55 || rdBusy[0] !== 1'b0) begin
         $display("FAIL sb_write_bypass got %h/%b exp 55/0", rdData[31:0], rdBusy[0]);
      end else passCount++;
      checkCount++;
      tick();
      clearStrobes();
      #1;
      if (busyCnt !== 6'd1 || rdBusy !== 2'b10 || rdData[31:0] !== 32'h55) begin
         $display("FAIL sb_after_write got %0d/%b/%h exp 1/10/55", busyCnt, rdBusy, rdData[31:0]);
      end else passCount++;
      checkCount++;
   endtask

   task automatic test_issue_write_same();
      logic [31:0] v;
      v = $urandom;
      issEn = 1'b1; issAddr = 5'd9;
      tick();
      wrEn = 1'b1; wrAddr = 5'd9; wrData = v;
      tick();
      clearStrobes();
      rdAddr = {5'd0, 5'd9};
      #1;
      if (rdData[31:0] !== v || rdBusy[0] !== 1'b1) begin
         $display("FAIL same_iss_wr got %h/%b exp %h/1", rdData[31:0], rdBusy[0], v);
      end else passCount++;
      checkCount++;
      if (busyCnt !== 6'd2) begin
         $display("FAIL same_iss_wr_cnt got %0d exp 2", busyCnt);
      end else passCount++;
      checkCount++;
   endtask

   task automatic test_flush();
      logic [4:0] probe [6];
      probe = '{5'd2, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12};
      issEn = 1'b1;
      issAddr = 5'd2;  tick();
      issAddr = 5'd10; tick();
      issAddr = 5'd11; tick();
      issEn = 1'b0;
      if (busyCnt !== 6'd5) begin
         $display("FAIL flush_pre_cnt got %0d exp 5", busyCnt);
      end else passCount++;
      checkCount++;
      flush = 1'b1; wrEn = 1'b1; wrAddr = 5'd2; wrData = 32'hA;
      issEn = 1'b1; issAddr = 5'd12;
      tick();
      clearStrobes();
      if (busyCnt !== 6'd0) begin
         $display("FAIL flush_cnt got %0d exp 0", busyCnt);
      end else passCount++;
      checkCount++;
      for (int k = 0; k < 6; k += 2) begin
         rdAddr = {probe[k+1], probe[k]};
         #1;
         if (rdBusy !== 2'b00) begin
            $display("FAIL flush_busy x%0d/x%0d got %b exp 00", probe[k], probe[k+1], rdBusy);
         end else passCount++;
         checkCount++;
      end
      rdAddr = {5'd0, 5'd2};
      #1;
      if (rdData[31:0] !== 32'hA) begin
         $display("FAIL flush_keeps_data got %h exp a", rdData[31:0]);
      end else passCount++;
      checkCount++;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [32:0] e;
      for (int n = 0; n < 400; n++) begin
         wrEn    = ($urandom_range(0, 2) != 0);
         issEn   = ($urandom_range(0, 2) != 0);
         flush   = ($urandom_range(0, 15) == 0);
         wrAddr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         issAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         wrData  = $urandom;
         rdAddr  = {5'($urandom_range(0, 7)), (n % 2 == 0) ? wrAddr : 5'($urandom_range(0, 7))};
         #1;
         for (int p = 0; p < 2; p++) begin
            e = modelRead(rdAddr[5*p +: 5]);
            if ({rdBusy[p], rdData[32*p +: 32]} !== e) begin
               $display("FAIL rand_read n=%0d port%0d x%0d got %b/%h exp %b/%h", n, p,
                        rdAddr[5*p +: 5], rdBusy[p], rdData[32*p +: 32], e[32], e[31:0]);
            end else passCount++;
            checkCount++;
         end
         tick();
         if (int'(busyCnt) !== modelCount()) begin
            $display("FAIL rand_busy_cnt n=%0d got %0d exp %0d", n, busyCnt, modelCount());
         end else passCount++;
         checkCount++;
      end
      clearStrobes();
   endtask

   task automatic test_reset_midop();
      issEn = 1'b1; issAddr = 5'd6; tick();
      wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hCAFEF00D;
      issEn = 1'b1; issAddr = 5'd13; flush = 1'b0;
      rdAddr = {5'd6, 5'd5};
      #2 rst = 1'b1;
      #1;
      if (rdData !== 64'd0 || rdBusy !== 2'b00 || busyCnt !== 6'd0) begin
         $display("FAIL midop_reset_imm got %h/%b/%0d exp 0/00/0", rdData, rdBusy, busyCnt);
      end else passCount++;
      checkCount++;
      @(posedge clk);
      #2 rst = 1'b0;
      clearStrobes();
      modelReset();
      @(negedge clk);
      rdAddr = {5'd13, 5'd5};
      #1;
      if (rdData !== 64'd0 || rdBusy !== 2'b00 || busyCnt !== 6'd0) begin
         $display("FAIL midop_reset_discard got %h/%b/%0d exp 0/00/0", rdData, rdBusy, busyCnt);
      end else passCount++;
      checkCount++;
   endtask

   task automatic test_wide_ports();
      logic [3:0]  wa [4];
      logic [63:0] nv;
      wa = '{4'd1, 4'd6, 4'd11, 4'd15};
      for (int k = 0; k < 4; k++) begin
         wVal[k] = {$urandom, $urandom};
         wWrEn = 1'b1; wWrAddr = wa[k]; wWrData = wVal[k];
         @(posedge clk);
         @(negedge clk);
      end
      wWrEn = 1'b0;
      wRdAddr = {wa[3], wa[2], wa[1], wa[0]};
      #1;
      for (int p = 0; p < 4; p++) begin
         if (wRdData[64*p +: 64] !== wVal[p]) begin
            $display("FAIL wide_read port%0d got %h exp %h", p, wRdData[64*p +: 64], wVal[p]);
         end else passCount++;
         checkCount++;
      end
      if (wRdBusy !== 4'b0000 || wBusyCnt !== 5'd0) begin
         $display("FAIL wide_busy got %b/%0d exp 0000/0", wRdBusy, wBusyCnt);
      end else passCount++;
      checkCount++;
      nv = {$urandom, $urandom};
      wWrEn = 1'b1; wWrAddr = wa[1]; wWrData = nv;
      wRdAddr = {wa[0], wa[1], 4'd0, wa[3]};
      #1;
      if (wRdData !== {wVal[0], nv, 64'd0, wVal[3]}) begin
         $display("FAIL wide_bypass got %h exp %h", wRdData, {wVal[0], nv, 64'd0, wVal[3]});
      end else passCount++;
      checkCount++;
      @(posedge clk);
      @(negedge clk);
      wWrEn = 1'b0;
   endtask

   initial begin
      modelReset();
      test_reset();
      test_write_bypass();
      test_zero_reg();
      test_scoreboard();
      test_issue_write_same();
      test_flush();
      test_random();
      test_reset_midop();
      test_wide_ports();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-read-port register file with a per-register busy scoreboard.
- Successor to the current 2R/1W negedge-write file. Adds:
  - configurable width, depth and read-port count
  - rising-edge write with same-cycle write-to-read bypass
  - asynchronous clear
  - pending-write tracking, so the pipeline can stall on a read of an in-flight destination register
- Sits between the decode/issue stage and writeback.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; depth = 2**ADDR_W
- NUM_RD, 2, number of combinational read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads 0, is never busy, and ignores writes/issues

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read indices; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  per-port flag: the addressed register has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback index
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue strobe: marks iss_addr busy
- iss_addr  in  ADDR_W  destination index of the issuing instruction
- flush  in  1  synchronous clear of all busy bits (pipeline flush); data is kept
- busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (async, rst=1):
  - all registers = 0
  - all busy bits = 0
  - busy_cnt = 0
  - rd_data/rd_busy reflect the cleared state combinationally
- Reset asserted mid-operation: takes effect immediately. Any same-cycle write, issue or flush is discarded.
- Write:
  - on the rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - if ZERO_REG=1 and wr_addr=0, the write is ignored.
- Read (combinational, per port i), priority order:
  1. ZERO_REG=1 and addr=0 -> data 0, busy 0.
  2. wr_en=1 and wr_addr=addr -> data wr_data (bypass), busy 0.
  3. Otherwise -> data reg[addr], busy busy[addr].
- Busy bit update, per register r, at the rising edge:
  - flush=1 -> all bits cleared; iss_en/wr_en busy effects that cycle ignored (the data write still occurs).
  - else set if iss_en and iss_addr=r.
  - else clear if wr_en and wr_addr=r.
  - Simultaneous issue and write to the same r: busy ends set (the new producer wins); the data is still written.
  - Issue to an already-busy register: stays busy; no count change.
  - Write to a non-busy register: legal, no busy effect.
  - ZERO_REG=1: index 0 is never set.
- busy_cnt:
  - registered; always equals the popcount of the busy bits after each edge.
  - net change per cycle in {-1, 0, +1} except on flush (-> 0).
  - Maximum 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG); no wrap.
- Latency:
  - write visible on a read through the bypass in the same cycle, and from the register array the next cycle.
  - busy set visible on rd_busy the cycle after the issue edge.
- Out-of-range NUM_RD: elaboration error.

Optional Feature:
- Macro: RF_DEBUG_PORT_EN.
- Defined: adds ports dbg_addr (in, ADDR_W) and dbg_data (out, DATA_W):
  - a read-only combinational tap for board display
  - same zero-register rule as the read ports, no bypass, no effect on busy state
- Undefined: the ports do not exist; no extra logic.

Test Plan:
- Reset then read: rst=1 pulse mid-cycle, ports 0/1 read x5/x31 -> rd_data=0, rd_busy=0, busy_cnt=0 immediately, before any clock edge.
- Write and bypass: wr_en=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr0=7 in the same cycle -> rd_data0=0xDEADBEEF, rd_busy0=0; next cycle with wr_en=0 -> still 0xDEADBEEF.
- Zero register: write x0=0x12345678 and issue x0 -> rd_data=0, rd_busy=0, busy_cnt unchanged (ZERO_REG=1).
- Scoreboard: issue x3 at edge 1, then x4 -> busy_cnt=1 then 2, rd_busy on x3 = 1. Write x3=0x55 -> in that cycle the x3 read gives 0x55 with busy 0; busy_cnt=1 after the edge.
- Simultaneous issue and write on x9, with x9 busy beforehand -> x9 reads the new data next cycle, rd_busy=1, busy_cnt unchanged.
- Flush: 5 registers busy, flush=1 with wr_en to x2=0xA -> busy_cnt=0, all rd_busy=0, x2=0xA retained. Also run NUM_RD=4, DATA_W=64 with four simultaneous distinct reads returning the correct values.
